masked_array: RTL and testbench

- Parametrised successor to the team's small flat register array, used for cache tag, data and metadata storage.
- Adds per-lane write masks, per-entry valid bits, and a sequential clear engine that sweeps all entries after reset or on flush.
- Keeps same-cycle write-to-read bypass and asynchronous (combinational) read.
- Sits beside the cache controller; the controller must not issue writes while busy is high.

---
 rtl/masked_array_if.sv | 31 +++
 rtl/masked_array.sv | 117 +++++++++++
 tb/tb_masked_array.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/masked_array_if.sv
// Bus bundle between the cache controller (master) and masked_array (slave):
// write port with lane masks, combinational read port, flush/busy and parity error hooks.
interface masked_array_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3,
  parameter int GRAN  = 8
);
  localparam int LANES = WIDTH / GRAN;

  logic             flush;
  logic             busy;
  logic             load;
  logic [IDX_W-1:0] windex;
  logic [LANES-1:0] wmask;
  logic [WIDTH-1:0] datain;
  logic [IDX_W-1:0] rindex;
  logic [WIDTH-1:0] dataout;
  logic             valid_out;
  logic             parity_flip;
  logic             parity_err;

  modport master (
    output flush, load, windex, wmask, datain, rindex, parity_flip,
    input  busy, dataout, valid_out, parity_err
  );

  modport slave (
    input  flush, load, windex, wmask, datain, rindex, parity_flip,
    output busy, dataout, valid_out, parity_err
  );
endinterface

// File: rtl/masked_array.sv
// Lane-masked register array with per-entry valid bits, a sequential clear sweep and
// same-cycle write-to-read bypass. Optional per-entry even parity: MASKED_ARRAY_PARITY_EN.
module masked_array #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3,
  parameter int GRAN  = 8
) (
  input  logic          clk,
  input  logic          rst,
  masked_array_if.slave bus
);
  localparam int LANES = WIDTH / GRAN;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic             wr_en;
  logic             bypass;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_v,
                                                   input logic [WIDTH-1:0] new_v,
                                                   input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) r[i*GRAN +: GRAN] = new_v[i*GRAN +: GRAN];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      S_CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
      end
      default: begin
        if (bus.flush) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
        end
      end
    endcase
  end

  // User writes only land in IDLE; a flush in the same cycle does not suppress them.
  assign wr_en   = (state == S_IDLE) && bus.load && !rst;
  assign bypass  = (state == S_IDLE) && bus.load && (bus.rindex == bus.windex);
  assign wr_data = merge_lanes(data_q[bus.windex], bus.datain, bus.wmask);

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      data_q[ptr]  <= '0;
      valid_q[ptr] <= 1'b0;
    end else if (wr_en) begin
      data_q[bus.windex]  <= wr_data;
      valid_q[bus.windex] <= 1'b1;
    end
  end

  always_comb begin
    rd_data       = '0;
    bus.valid_out = 1'b0;
    if (state == S_IDLE) begin
      if (bypass) begin
        rd_data       = merge_lanes(data_q[bus.rindex], bus.datain, bus.wmask);
        bus.valid_out = 1'b1;
      end else begin
        rd_data       = data_q[bus.rindex];
        bus.valid_out = valid_q[bus.rindex];
      end
    end
  end

  assign bus.dataout = rd_data;
  assign bus.busy    = (state == S_CLEAR);

`ifdef MASKED_ARRAY_PARITY_EN
  logic [DEPTH-1:0] par_q;

  // Parity covers the merged entry, so it is valid even after a partial-lane write.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      par_q[ptr] <= 1'b0;
    end else if (wr_en) begin
      par_q[bus.windex] <= (^wr_data) ^ bus.parity_flip;
    end
  end

  assign bus.parity_err = bus.valid_out & ~bypass & ((^rd_data) ^ par_q[bus.rindex]);
`else
  logic unused_parity_flip;
  assign unused_parity_flip = bus.parity_flip;
  assign bus.parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_masked_array.sv
// Directed bench for masked_array: reset sweep, masked writes, bypass, flush, reset
// mid-sweep and parity injection, checked through an expected-result queue.
module tb_masked_array;
  logic clk = 1'b0;
  logic rst;

  masked_array_if #(.WIDTH(32), .IDX_W(3), .GRAN(8)) bus ();

  masked_array #(.WIDTH(32), .IDX_W(3), .GRAN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #20 clk = ~clk;

  typedef struct {
    string       tag;
    logic [34:0] exp;
  } item_t;

  item_t sb[$];
  int    tests  = 0;
  int    failed = 0;

`ifdef MASKED_ARRAY_PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  // Expected layout: {busy, valid_out, parity_err, dataout}
  task automatic chk(input string tag, input logic [31:0] d, input logic v,
                     input logic p, input logic b);
    item_t       it;
    logic [34:0] obs;
    sb.push_back('{tag, {b, v, p, d}});
    #1;
    it  = sb.pop_front();
    obs = {bus.busy, bus.valid_out, bus.parity_err, bus.dataout};
    tests++;
    assert (obs === it.exp)
      else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.flush       = 1'b0;
    bus.load        = 1'b0;
    bus.windex      = '0;
    bus.wmask       = '0;
    bus.datain      = '0;
    bus.rindex      = '0;
    bus.parity_flip = 1'b0;
  endtask

  task automatic write(input logic [2:0] idx, input logic [3:0] m, input logic [31:0] d);
    bus.load   = 1'b1;
    bus.windex = idx;
    bus.wmask  = m;
    bus.datain = d;
  endtask

  task automatic check_all_clear(input string tag);
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.rindex = 3'(i);
      chk($sformatf("%s_e%0d", tag, i), 32'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset sweep: busy for 8 samples, reads forced to zero, loads ignored
    for (int c = 0; c < 8; c++) begin
      write(3'(c), 4'hF, 32'hCAFE0000 | 32'(c));
      bus.rindex = 3'(c);
      chk($sformatf("sweep_c%0d", c), 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check_all_clear("after_reset");

    // Masked write with bypass on both writes
    write(3'd5, 4'b1111, 32'hAABBCCDD);
    bus.rindex = 3'd5;
    chk("mw_full_bypass", 32'hAABBCCDD, 1'b1, 1'b0, 1'b0);
    tick();
    write(3'd5, 4'b0101, 32'h11223344);
    chk("mw_part_bypass", 32'hAA22CC44, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load = 1'b0;
    chk("mw_stored", 32'hAA22CC44, 1'b1, 1'b0, 1'b0);

    // Bypass on a single upper lane, plus a read of a different index during a write
    write(3'd2, 4'b1111, 32'h12345678);
    bus.rindex = 3'd5;
    chk("no_bypass_other_idx", 32'hAA22CC44, 1'b1, 1'b0, 1'b0);
    tick();
    write(3'd2, 4'b1000, 32'hFF000000);
    bus.rindex = 3'd2;
    chk("bypass_lane3", 32'hFF345678, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load = 1'b0;
    chk("bypass_stored", 32'hFF345678, 1'b1, 1'b0, 1'b0);

    // wmask=0 still sets valid without touching data
    write(3'd4, 4'b0000, 32'hFFFFFFFF);
    bus.rindex = 3'd4;
    chk("mask0_bypass", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load = 1'b0;
    chk("mask0_stored", 32'h0, 1'b1, 1'b0, 1'b0);
    bus.rindex = 3'd6;
    chk("unwritten_idx6", 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush with a same-cycle load; loads during the sweep are dropped
    write(3'd7, 4'hF, 32'hDEADBEEF);
    bus.flush  = 1'b1;
    bus.rindex = 3'd7;
    chk("flush_load_bypass", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      write(3'd1, 4'hF, 32'h55555555);
      bus.rindex = 3'd7;
      chk($sformatf("flush_sweep_c%0d", c), 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    bus.flush = 1'b0;
    check_all_clear("after_flush");

    // Reset at sweep cycle 4 restarts the full 8-cycle sweep
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pre_rst_c%0d", c), 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    rst = 1'b1;
    chk("rst_at_c4", 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("restart_c%0d", c), 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    chk("restart_done", 32'h0, 1'b0, 1'b0, 1'b0);

    // Parity injection and repair
    write(3'd3, 4'hF, 32'h00000001);
    bus.parity_flip = 1'b1;
    bus.rindex      = 3'd3;
    chk("par_flip_bypass", 32'h1, 1'b1, 1'b0, 1'b0);
    tick();
    bus.load        = 1'b0;
    bus.parity_flip = 1'b0;
    chk("par_flip_stored", 32'h1, 1'b1, PAR_ON, 1'b0);
    tick();
    write(3'd3, 4'hF, 32'h00000001);
    tick();
    bus.load = 1'b0;
    chk("par_rewrite", 32'h1, 1'b1, 1'b0, 1'b0);
    write(3'd0, 4'b0010, 32'h00000300);
    tick();
    bus.load   = 1'b0;
    bus.rindex = 3'd0;
    chk("par_partial_clean", 32'h00000300, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
